// File: rtl/control_multicycle.sv
`default_nettype none
// ============================================================================
// Module      : control_multicycle
// Description : Multi-cycle control unit. Owns the instruction register and a
//               FETCH/DECODE/EXEC/MEM/WB sequencer with a bounded memory wait.
// Revision    : 1.0 - initial release
// ============================================================================
module control_multicycle #(
    parameter int MEM_TIMEOUT = 16,
    parameter int LINK_REG    = 31
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    input  logic        zero,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        reg_write,
    output logic [1:0]  wb_src,
    output logic [1:0]  alu_src,
    output logic [2:0]  alu_op,
    output logic [4:0]  addr_a,
    output logic [4:0]  addr_b,
    output logic [4:0]  addr_in,
    output logic [4:0]  shamt,
    output logic [15:0] imm16,
    output logic [25:0] addr26,
    output logic [2:0]  state,
    output logic        fault
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    localparam logic [WAIT_W-1:0] c_wait_limit = WAIT_W'(MEM_TIMEOUT);
    localparam logic [4:0]        c_link_reg   = 5'(LINK_REG);

    localparam logic [2:0] c_st_fetch  = 3'd0;
    localparam logic [2:0] c_st_decode = 3'd1;
    localparam logic [2:0] c_st_exec   = 3'd2;
    localparam logic [2:0] c_st_mem    = 3'd3;
    localparam logic [2:0] c_st_wb     = 3'd4;
    localparam logic [2:0] c_st_fault  = 3'd7;

    // ALU operation and operand-select encodings shared with the datapath
    localparam logic [2:0] c_op_add = 3'd0;
    localparam logic [2:0] c_op_sub = 3'd1;
    localparam logic [2:0] c_op_and = 3'd2;
    localparam logic [2:0] c_op_or  = 3'd3;
    localparam logic [2:0] c_op_nor = 3'd4;
    localparam logic [2:0] c_op_slt = 3'd5;
    localparam logic [2:0] c_op_sll = 3'd6;
    localparam logic [2:0] c_op_srl = 3'd7;

    localparam logic [1:0] c_src_reg   = 2'd0;
    localparam logic [1:0] c_src_sext  = 2'd1;
    localparam logic [1:0] c_src_zext  = 2'd2;
    localparam logic [1:0] c_src_shamt = 2'd3;

    logic [2:0]        state_q, state_d;
    logic [31:0]       ir_q, ir_d;
    logic [WAIT_W-1:0] wait_q, wait_d;

    logic [5:0] w_op, w_funct;
    logic [4:0] w_rs, w_rt, w_rd;
    logic       w_legal, w_is_rtype, w_is_shift, w_is_alu;
    logic       w_is_lw, w_is_sw, w_is_beq, w_is_bne, w_is_j, w_is_jal, w_is_jr;
    logic       w_timeout;

    assign w_op    = ir_q[31:26];
    assign w_funct = ir_q[5:0];
    assign w_rs    = ir_q[25:21];
    assign w_rt    = ir_q[20:16];
    assign w_rd    = ir_q[15:11];

    // Instruction decode
    always_comb begin
        w_legal    = 1'b0;
        w_is_rtype = 1'b0;
        w_is_shift = 1'b0;
        w_is_alu   = 1'b0;
        w_is_lw    = 1'b0;
        w_is_sw    = 1'b0;
        w_is_beq   = 1'b0;
        w_is_bne   = 1'b0;
        w_is_j     = 1'b0;
        w_is_jal   = 1'b0;
        w_is_jr    = 1'b0;
        alu_op     = c_op_add;
        alu_src    = c_src_reg;
        case (w_op)
            6'h00: begin
                w_is_rtype = 1'b1;
                case (w_funct)
                    6'h20: begin w_legal = 1'b1; w_is_alu = 1'b1; alu_op = c_op_add; end
                    6'h22: begin w_legal = 1'b1; w_is_alu = 1'b1; alu_op = c_op_sub; end
                    6'h24: begin w_legal = 1'b1; w_is_alu = 1'b1; alu_op = c_op_and; end
                    6'h25: begin w_legal = 1'b1; w_is_alu = 1'b1; alu_op = c_op_or;  end
                    6'h27: begin w_legal = 1'b1; w_is_alu = 1'b1; alu_op = c_op_nor; end
                    6'h2A: begin w_legal = 1'b1; w_is_alu = 1'b1; alu_op = c_op_slt; end
                    6'h00: begin
                        w_legal = 1'b1; w_is_alu = 1'b1; w_is_shift = 1'b1;
                        alu_op = c_op_sll; alu_src = c_src_shamt;
                    end
                    6'h02: begin
                        w_legal = 1'b1; w_is_alu = 1'b1; w_is_shift = 1'b1;
                        alu_op = c_op_srl; alu_src = c_src_shamt;
                    end
                    6'h08: begin w_legal = 1'b1; w_is_jr = 1'b1; end
                    default: ;
                endcase
            end
            6'h08: begin w_legal = 1'b1; w_is_alu = 1'b1; alu_src = c_src_sext; end
            6'h0C: begin w_legal = 1'b1; w_is_alu = 1'b1; alu_op = c_op_and; alu_src = c_src_zext; end
            6'h0D: begin w_legal = 1'b1; w_is_alu = 1'b1; alu_op = c_op_or;  alu_src = c_src_zext; end
            6'h23: begin w_legal = 1'b1; w_is_lw = 1'b1; alu_src = c_src_sext; end
            6'h2B: begin w_legal = 1'b1; w_is_sw = 1'b1; alu_src = c_src_sext; end
            6'h04: begin w_legal = 1'b1; w_is_beq = 1'b1; alu_op = c_op_sub; end
            6'h05: begin w_legal = 1'b1; w_is_bne = 1'b1; alu_op = c_op_sub; end
            6'h02: begin w_legal = 1'b1; w_is_j = 1'b1; end
            6'h03: begin w_legal = 1'b1; w_is_jal = 1'b1; end
            default: ;
        endcase
    end

    assign addr_a  = w_is_shift ? w_rt : w_rs;
    assign addr_b  = w_rt;
    assign addr_in = w_is_jal ? c_link_reg : (w_is_rtype ? w_rd : w_rt);
    assign shamt   = w_is_shift ? ir_q[10:6] : 5'd0;
    assign wb_src  = w_is_jal ? 2'd2 : (w_is_lw ? 2'd1 : 2'd0);
    assign imm16   = ir_q[15:0];
    assign addr26  = ir_q[25:0];
    assign state   = state_q;
    assign fault   = (state_q == c_st_fault);

    assign w_timeout = (wait_q == c_wait_limit);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= c_st_fetch;
            ir_q    <= 32'd0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            wait_q  <= wait_d;
        end
    end

    // Next state; the wait counter restarts whenever FETCH/MEM is (re)entered
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        wait_d  = '0;
        case (state_q)
            c_st_fetch: begin
                if (mem_ready) begin
                    state_d = c_st_decode;
                    ir_d    = mem_rdata;
                end else if (w_timeout) begin
                    state_d = c_st_fault;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            c_st_decode: state_d = w_legal ? c_st_exec : c_st_fault;
            c_st_exec: begin
                if (w_is_lw || w_is_sw)
                    state_d = c_st_mem;
                else if (w_is_alu)
                    state_d = c_st_wb;
                else if (w_is_beq || w_is_bne || w_is_j || w_is_jal || w_is_jr)
                    state_d = c_st_fetch;
                else
                    state_d = c_st_fault;
            end
            c_st_mem: begin
                if (mem_ready)
                    state_d = w_is_lw ? c_st_wb : c_st_fetch;
                else if (w_timeout)
                    state_d = c_st_fault;
                else
                    wait_d = wait_q + 1'b1;
            end
            c_st_wb:    state_d = c_st_fetch;
            c_st_fault: state_d = c_st_fault;
            default:    state_d = c_st_fault;
        endcase
    end

    // Strobes; all suppressed while reset is held
    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = 2'd0;
        reg_write    = 1'b0;
        case (state_q)
            c_st_fetch: begin
                mem_req  = 1'b1;
                ir_write = mem_ready;
                pc_write = mem_ready;
            end
            c_st_exec: begin
                if (w_is_beq || w_is_bne) begin
                    pc_write = zero ^ w_is_bne;
                    pc_src   = 2'd1;
                end else if (w_is_j || w_is_jal) begin
                    pc_write = 1'b1;
                    pc_src   = 2'd2;
                end else if (w_is_jr) begin
                    pc_write = 1'b1;
                    pc_src   = 2'd3;
                end
                reg_write = w_is_jal;
            end
            c_st_mem: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = w_is_sw;
            end
            c_st_wb: reg_write = 1'b1;
            default: ;
        endcase
        if (reset) begin
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            reg_write = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_control_multicycle.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_multicycle
// Description : Directed self-checking bench for control_multicycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_control_multicycle;

    localparam int MT = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_ready = 1'b0;
    logic        zero = 1'b0;
    logic        mem_req, mem_we, mem_addr_sel, ir_write, pc_write, reg_write, fault;
    logic [1:0]  pc_src, wb_src, alu_src;
    logic [2:0]  alu_op, state;
    logic [4:0]  addr_a, addr_b, addr_in, shamt;
    logic [15:0] imm16;
    logic [25:0] addr26;

    int n_cmp = 0;
    int n_err = 0;

    control_multicycle #(.MEM_TIMEOUT(MT), .LINK_REG(31)) dut (
        .clk(clk), .reset(reset), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .zero(zero), .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .reg_write(reg_write), .wb_src(wb_src), .alu_src(alu_src), .alu_op(alu_op),
        .addr_a(addr_a), .addr_b(addr_b), .addr_in(addr_in), .shamt(shamt),
        .imm16(imm16), .addr26(addr26), .state(state), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic apply_reset();
        reset = 1'b1; mem_ready = 1'b0; zero = 1'b0;
        tick();
        reset = 1'b0;
        #1;
    endtask

    // Completes a fetch of instr; returns in DECODE
    task automatic do_fetch(input logic [31:0] instr);
        mem_rdata = instr; mem_ready = 1'b1;
        #1;
        tick();
        mem_ready = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        tick(); tick();
        n_cmp++;
        if ({state, mem_req, mem_we, ir_write, pc_write, reg_write, fault} !== 9'd0) begin
            n_err++;
            $display("FAIL reset_hold: got st=%0d req=%b we=%b irw=%b pcw=%b rw=%b flt=%b want all 0",
                     state, mem_req, mem_we, ir_write, pc_write, reg_write, fault);
        end
        reset = 1'b0; mem_ready = 1'b0;
        #1;
        n_cmp++;
        if ({state, mem_req, mem_addr_sel, ir_write, imm16, addr26} !== {3'd0, 1'b1, 1'b0, 1'b0, 16'd0, 26'd0}) begin
            n_err++;
            $display("FAIL reset_release: got st=%0d req=%b asel=%b irw=%b imm=%h a26=%h want st=0 req=1 asel=0 irw=0 imm=0 a26=0",
                     state, mem_req, mem_addr_sel, ir_write, imm16, addr26);
        end
    endtask

    task automatic test_addi();
        mem_rdata = 32'h2010_FEFE; mem_ready = 1'b1;
        #1;
        n_cmp++;
        if ({ir_write, pc_write, pc_src, mem_req, mem_addr_sel} !== 6'b110010) begin
            n_err++;
            $display("FAIL addi_fetch: got irw=%b pcw=%b src=%0d req=%b asel=%b want 1 1 0 1 0",
                     ir_write, pc_write, pc_src, mem_req, mem_addr_sel);
        end
        tick(); mem_ready = 1'b0; #1;
        n_cmp++;
        if ({state, mem_req, mem_we, ir_write, pc_write, reg_write} !== {3'd1, 5'd0}) begin
            n_err++;
            $display("FAIL addi_decode: got st=%0d strobes=%b want st=1 strobes=00000",
                     state, {mem_req, mem_we, ir_write, pc_write, reg_write});
        end
        tick();
        n_cmp++;
        if ({state, mem_req, pc_write, reg_write} !== {3'd2, 3'd0}) begin
            n_err++;
            $display("FAIL addi_exec: got st=%0d req=%b pcw=%b rw=%b want st=2 0 0 0",
                     state, mem_req, pc_write, reg_write);
        end
        tick();
        n_cmp++;
        if ({state, reg_write, addr_in, alu_op, alu_src, wb_src, imm16} !==
            {3'd4, 1'b1, 5'd16, 3'd0, 2'd1, 2'd0, 16'hFEFE}) begin
            n_err++;
            $display("FAIL addi_wb: got st=%0d rw=%b ain=%0d op=%0d src=%0d wb=%0d imm=%h want 4 1 16 0 1 0 fefe",
                     state, reg_write, addr_in, alu_op, alu_src, wb_src, imm16);
        end
        tick();
        n_cmp++;
        if (state !== 3'd0) begin
            n_err++;
            $display("FAIL addi_return: got st=%0d want 0", state);
        end
    endtask

    task automatic test_shift_and();
        do_fetch(32'h0010_8400);
        mem_ready = 1'b1;  // must be ignored in DECODE
        #1;
        n_cmp++;
        if ({state, ir_write, pc_write, mem_req} !== {3'd1, 3'd0}) begin
            n_err++;
            $display("FAIL decode_ignores_ready: got st=%0d irw=%b pcw=%b req=%b want 1 0 0 0",
                     state, ir_write, pc_write, mem_req);
        end
        n_cmp++;
        if ({addr_a, addr_in, shamt, alu_op, alu_src} !== {5'd16, 5'd16, 5'd16, 3'd6, 2'd3}) begin
            n_err++;
            $display("FAIL sll_fields: got a=%0d in=%0d sh=%0d op=%0d src=%0d want 16 16 16 6 3",
                     addr_a, addr_in, shamt, alu_op, alu_src);
        end
        mem_ready = 1'b0;
        tick(); tick(); tick();
        do_fetch(32'h0211_4024);
        n_cmp++;
        if ({addr_a, addr_b, addr_in, shamt, alu_op, alu_src} !== {5'd16, 5'd17, 5'd8, 5'd0, 3'd2, 2'd0}) begin
            n_err++;
            $display("FAIL and_fields: got a=%0d b=%0d in=%0d sh=%0d op=%0d src=%0d want 16 17 8 0 2 0",
                     addr_a, addr_b, addr_in, shamt, alu_op, alu_src);
        end
        tick(); tick(); tick();
    endtask

    task automatic test_lw_sw();
        do_fetch(32'h8E08_0004);
        tick(); tick();
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if ({state, mem_req, mem_addr_sel, mem_we} !== {3'd3, 3'b110}) begin
                n_err++;
                $display("FAIL lw_mem_wait%0d: got st=%0d req=%b asel=%b we=%b want 3 1 1 0",
                         i, state, mem_req, mem_addr_sel, mem_we);
            end
            tick();
        end
        mem_ready = 1'b1; #1;
        n_cmp++;
        if ({state, ir_write, reg_write} !== {3'd3, 2'b00}) begin
            n_err++;
            $display("FAIL lw_mem_done: got st=%0d irw=%b rw=%b want 3 0 0", state, ir_write, reg_write);
        end
        tick(); mem_ready = 1'b0; #1;
        n_cmp++;
        if ({state, reg_write, wb_src, addr_in} !== {3'd4, 1'b1, 2'd1, 5'd8}) begin
            n_err++;
            $display("FAIL lw_wb: got st=%0d rw=%b wb=%0d in=%0d want 4 1 1 8", state, reg_write, wb_src, addr_in);
        end
        tick();
        do_fetch(32'hAD10_0000);
        tick();
        n_cmp++;
        if ({state, mem_we} !== {3'd2, 1'b0}) begin
            n_err++;
            $display("FAIL sw_exec: got st=%0d we=%b want 2 0", state, mem_we);
        end
        tick(); mem_ready = 1'b1; #1;
        n_cmp++;
        if ({state, mem_we, mem_req, mem_addr_sel, reg_write} !== {3'd3, 4'b1110}) begin
            n_err++;
            $display("FAIL sw_mem: got st=%0d we=%b req=%b asel=%b rw=%b want 3 1 1 1 0",
                     state, mem_we, mem_req, mem_addr_sel, reg_write);
        end
        tick(); mem_ready = 1'b0; #1;
        n_cmp++;
        if ({state, mem_we, reg_write} !== {3'd0, 2'b00}) begin
            n_err++;
            $display("FAIL sw_done: got st=%0d we=%b rw=%b want 0 0 0", state, mem_we, reg_write);
        end
    endtask

    task automatic test_branch_jump();
        do_fetch(32'h1520_FFFD);
        zero = 1'b0;
        tick();
        n_cmp++;
        if ({state, pc_write, pc_src, alu_op, reg_write} !== {3'd2, 1'b1, 2'd1, 3'd1, 1'b0}) begin
            n_err++;
            $display("FAIL bne_taken: got st=%0d pcw=%b src=%0d op=%0d rw=%b want 2 1 1 1 0",
                     state, pc_write, pc_src, alu_op, reg_write);
        end
        tick();
        n_cmp++;
        if (state !== 3'd0) begin
            n_err++;
            $display("FAIL bne_return: got st=%0d want 0", state);
        end
        do_fetch(32'h1520_FFFD);
        zero = 1'b1;
        tick();
        n_cmp++;
        if ({state, pc_write} !== {3'd2, 1'b0}) begin
            n_err++;
            $display("FAIL bne_not_taken: got st=%0d pcw=%b want 2 0", state, pc_write);
        end
        tick(); zero = 1'b0;
        do_fetch(32'h0C00_0010);
        tick();
        n_cmp++;
        if ({state, pc_write, pc_src, reg_write, addr_in, wb_src, addr26} !==
            {3'd2, 1'b1, 2'd2, 1'b1, 5'd31, 2'd2, 26'h10}) begin
            n_err++;
            $display("FAIL jal_exec: got st=%0d pcw=%b src=%0d rw=%b in=%0d wb=%0d a26=%h want 2 1 2 1 31 2 10",
                     state, pc_write, pc_src, reg_write, addr_in, wb_src, addr26);
        end
        tick();
        n_cmp++;
        if (state !== 3'd0) begin
            n_err++;
            $display("FAIL jal_return: got st=%0d want 0", state);
        end
        do_fetch(32'h03E0_0008);
        tick();
        n_cmp++;
        if ({pc_write, pc_src, addr_a, reg_write} !== {1'b1, 2'd3, 5'd31, 1'b0}) begin
            n_err++;
            $display("FAIL jr_exec: got pcw=%b src=%0d a=%0d rw=%b want 1 3 31 0",
                     pc_write, pc_src, addr_a, reg_write);
        end
        tick();
    endtask

    task automatic test_timeout();
        apply_reset();
        mem_rdata = 32'd0;
        for (int i = 0; i < MT; i++) tick();
        n_cmp++;
        if (state !== 3'd0) begin
            n_err++;
            $display("FAIL fetch_before_limit: got st=%0d want 0", state);
        end
        tick();
        n_cmp++;
        if ({state, fault} !== {3'd7, 1'b1}) begin
            n_err++;
            $display("FAIL fetch_timeout: got st=%0d flt=%b want 7 1", state, fault);
        end
        mem_ready = 1'b1;
        tick(); tick();
        n_cmp++;
        if ({state, fault, mem_req, ir_write, pc_write} !== {3'd7, 1'b1, 3'b000}) begin
            n_err++;
            $display("FAIL fault_sticky: got st=%0d flt=%b req=%b irw=%b pcw=%b want 7 1 0 0 0",
                     state, fault, mem_req, ir_write, pc_write);
        end
        apply_reset();
        for (int i = 0; i < MT; i++) tick();
        mem_ready = 1'b1; #1;
        n_cmp++;
        if (ir_write !== 1'b1) begin
            n_err++;
            $display("FAIL threshold_ready_irw: got %b want 1", ir_write);
        end
        tick(); mem_ready = 1'b0; #1;
        n_cmp++;
        if ({state, fault} !== {3'd1, 1'b0}) begin
            n_err++;
            $display("FAIL threshold_ready: got st=%0d flt=%b want 1 0", state, fault);
        end
        apply_reset();
        do_fetch(32'hAD10_0000);
        tick(); tick();
        for (int i = 0; i < MT; i++) tick();
        n_cmp++;
        if (state !== 3'd3) begin
            n_err++;
            $display("FAIL mem_before_limit: got st=%0d want 3", state);
        end
        tick();
        n_cmp++;
        if ({state, fault, mem_we} !== {3'd7, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL mem_timeout: got st=%0d flt=%b we=%b want 7 1 0", state, fault, mem_we);
        end
    endtask

    task automatic test_illegal();
        apply_reset();
        do_fetch(32'hFC00_0000);
        tick();
        n_cmp++;
        if ({state, fault} !== {3'd7, 1'b1}) begin
            n_err++;
            $display("FAIL illegal_opcode: got st=%0d flt=%b want 7 1", state, fault);
        end
        apply_reset();
        do_fetch(32'h0000_003F);
        tick();
        n_cmp++;
        if (state !== 3'd7) begin
            n_err++;
            $display("FAIL illegal_funct: got st=%0d want 7", state);
        end
    endtask

    task automatic test_reset_mid_mem();
        apply_reset();
        do_fetch(32'hAD10_0000);
        tick(); tick(); tick();
        n_cmp++;
        if ({state, mem_we} !== {3'd3, 1'b1}) begin
            n_err++;
            $display("FAIL sw_mem_wait: got st=%0d we=%b want 3 1", state, mem_we);
        end
        reset = 1'b1; mem_ready = 1'b1; #1;
        n_cmp++;
        if ({mem_we, mem_req, ir_write, pc_write, reg_write} !== 5'd0) begin
            n_err++;
            $display("FAIL reset_mid_mem_strobes: got %b want 00000",
                     {mem_we, mem_req, ir_write, pc_write, reg_write});
        end
        tick();
        n_cmp++;
        if ({state, mem_we, mem_req, ir_write} !== {3'd0, 3'b000}) begin
            n_err++;
            $display("FAIL reset_mid_mem_state: got st=%0d we=%b req=%b irw=%b want 0 0 0 0",
                     state, mem_we, mem_req, ir_write);
        end
        reset = 1'b0; mem_ready = 1'b0; #1;
        n_cmp++;
        if ({state, mem_req} !== {3'd0, 1'b1}) begin
            n_err++;
            $display("FAIL reset_mid_mem_release: got st=%0d req=%b want 0 1", state, mem_req);
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_shift_and();
        test_lw_sw();
        test_branch_jump();
        test_timeout();
        test_illegal();
        test_reset_mid_mem();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
